// File: rtl/branch_predictor_if.sv
// Port bundle for branch_predictor: fetch-side lookup, execute-side update,
// and the status/performance outputs.
interface branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  // There is no ready: the predictor accepts an update in every cycle that
  // upd_valid is high, and the lookup outputs are valid in every cycle.
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic             upd_taken;
  logic             upd_pred_taken;
  logic [PC_W-1:0]  upd_pred_target;
  logic             invalidate_all;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_pred_taken, upd_pred_target, invalidate_all,
    input  pred_hit, pred_taken, pred_target, mispredict,
           branch_cnt, mispredict_cnt
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_pred_taken, upd_pred_target, invalidate_all,
    output pred_hit, pred_taken, pred_target, mispredict,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// a registered mispredict pulse and saturating performance counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_cnt_nxt;
  logic             u_mis;
  logic             unused_pc_lsbs;

  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[PC_W-1:IDX_W+2];
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign bp.pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign bp.pred_taken  = bp.pred_hit && cnt_q[l_idx][1];
  assign bp.pred_target = bp.pred_taken ? tgt_q[l_idx] : bp.lookup_pc + PC_W'(4);

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_mis = (bp.upd_taken != bp.upd_pred_taken) ||
                 (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));

  always_comb begin
    u_cnt_nxt = cnt_q[u_idx];
    if (bp.upd_taken && (cnt_q[u_idx] != 2'b11)) begin
      u_cnt_nxt = cnt_q[u_idx] + 2'b01;
    end else if (!bp.upd_taken && (cnt_q[u_idx] != 2'b00)) begin
      u_cnt_nxt = cnt_q[u_idx] - 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (bp.invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bp.upd_valid) begin
      if (u_hit) begin
        cnt_q[u_idx] <= u_cnt_nxt;
        if (bp.upd_taken) begin
          tgt_q[u_idx] <= bp.upd_target;
        end
      end else if (bp.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= bp.upd_target;
        cnt_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Statistics keep counting through invalidate_all; only reset clears them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bp.mispredict     <= 1'b0;
      bp.branch_cnt     <= '0;
      bp.mispredict_cnt <= '0;
    end else begin
      bp.mispredict <= bp.upd_valid && u_mis;
      if (bp.upd_valid && (bp.branch_cnt != {CNT_W{1'b1}})) begin
        bp.branch_cnt <= bp.branch_cnt + 1'b1;
      end
      if (bp.upd_valid && u_mis && (bp.mispredict_cnt != {CNT_W{1'b1}})) begin
        bp.mispredict_cnt <= bp.mispredict_cnt + 1'b1;
      end
    end
  end
endmodule
